// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - serial frame receiver with parity/framing check and error counter
//
// Receives start + DATA_W data bits (LSB first) + parity + stop, sampling each
// bit at its centre, and reports the word with a one-cycle strobe.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   rx_in       serial line, idle high, already synchronous to clk
//   clr_count   synchronous clear of err_count (wins over an increment)
//   data_out    last received data word (updates on error frames too)
//   data_valid  one-cycle pulse per completed frame
//   parity_err  parity mismatch of the last strobed frame (held)
//   frame_err   stop bit sampled low in the last strobed frame (held)
//   busy        high while the receiver is not idle
//   err_count   saturating count of frames with parity or framing error
module parity_frame_rx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  input  logic              clr_count,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic             ODD_BIT  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                busy_q, busy_d;
  logic [7:0]          errcnt_q, errcnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    errcnt_d = errcnt_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_in) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Re-check the line at the start bit centre; a high here was a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_in) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_in;
          if (idx_q == IDX_LAST) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_in;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          data_d  = shift_q;
          valid_d = 1'b1;
          perr_d  = (par_q != (^shift_q ^ ODD_BIT));
          ferr_d  = ~rx_in;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Counting happens on the edge that closes the strobe cycle, so a clear
    // issued alongside the strobe takes priority.
    if (clr_count) begin
      errcnt_d = '0;
    end else if (valid_q && (perr_q || ferr_q) && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;
  assign err_count  = errcnt_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb/tb_parity_frame_rx.sv - self-checking bench for parity_frame_rx (even and odd instances)
module tb_parity_frame_rx;

  localparam int W    = 4;
  localparam int C    = 4;
  localparam int H    = C / 2;
  localparam int DV_N = H + C * (W + 2) + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_in = 1'b1;
  logic         clr_count = 1'b0;

  logic [W-1:0] e_data, o_data;
  logic         e_valid, o_valid, e_perr, o_perr, e_ferr, o_ferr, e_busy, o_busy;
  logic [7:0]   e_cnt, o_cnt;

  parity_frame_rx #(.DATA_W(W), .CLKS_PER_BIT(C), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .clr_count(clr_count),
    .data_out(e_data), .data_valid(e_valid), .parity_err(e_perr),
    .frame_err(e_ferr), .busy(e_busy), .err_count(e_cnt)
  );

  parity_frame_rx #(.DATA_W(W), .CLKS_PER_BIT(C), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .clr_count(clr_count),
    .data_out(o_data), .data_valid(o_valid), .parity_err(o_perr),
    .frame_err(o_ferr), .busy(o_busy), .err_count(o_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt_e = 0;
  int exp_cnt_o = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         par;
    logic         stop;
    logic         exp_pe;
    logic         exp_fe;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Parity error if the received bit differs from the parity the sender should
  // have produced for this data word.
  function automatic logic ref_perr(input logic [W-1:0] d, input logic p, input logic odd);
    int  ones;
    logic want;
    ones = $countones(d);
    want = ((ones % 2) == 1);
    if (odd) want = ~want;
    return (p != want);
  endfunction

  // Line level n cycles after the start bit begins; stop is held just past its centre.
  function automatic logic line_at(input logic [W-1:0] d, input logic p, input logic s, input int n);
    if (n < C) return 1'b0;
    if (n < C * (W + 1)) return d[n / C - 1];
    if (n < C * (W + 2)) return p;
    if (n < C * (W + 2) + H + 1) return s;
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [W-1:0] d, input logic p, input logic s,
                            input logic clr_at_dv, input bit use_tab,
                            input logic tab_pe, input logic tab_fe, input string tag);
    int   dv_e = 0;
    int   dv_o = 0;
    bit   busy_bad = 0;
    logic pe_e, pe_o, fe;
    pe_e = ref_perr(d, p, 1'b0);
    pe_o = ref_perr(d, p, 1'b1);
    fe   = ~s;
    for (int n = 0; n <= DV_N + 3; n++) begin
      @(negedge clk);
      if (n >= 1) begin
        if (e_valid) dv_e++;
        if (o_valid) dv_o++;
      end
      if (((n >= 1) && (n < DV_N)) != e_busy) busy_bad = 1;
      if (((n >= 1) && (n < DV_N)) != o_busy) busy_bad = 1;
      if (n == DV_N) begin
        chk({tag, " data_valid even"}, int'(e_valid), 1);
        chk({tag, " data_valid odd"}, int'(o_valid), 1);
        chk({tag, " data_out"}, int'(e_data), int'(d));
        chk({tag, " data_out odd"}, int'(o_data), int'(d));
        chk({tag, " parity_err even"}, int'(e_perr), int'(pe_e));
        chk({tag, " parity_err odd"}, int'(o_perr), int'(pe_o));
        chk({tag, " frame_err"}, int'(e_ferr), int'(fe));
        chk({tag, " frame_err odd"}, int'(o_ferr), int'(fe));
        if (use_tab) begin
          chk({tag, " parity_err table"}, int'(e_perr), int'(tab_pe));
          chk({tag, " frame_err table"}, int'(e_ferr), int'(tab_fe));
        end
      end
      if (n == DV_N + 1) begin
        if (clr_at_dv) begin
          exp_cnt_e = 0;
          exp_cnt_o = 0;
        end else begin
          if ((pe_e || fe) && exp_cnt_e < 255) exp_cnt_e++;
          if ((pe_o || fe) && exp_cnt_o < 255) exp_cnt_o++;
        end
        chk({tag, " err_count even"}, int'(e_cnt), exp_cnt_e);
        chk({tag, " err_count odd"}, int'(o_cnt), exp_cnt_o);
        chk({tag, " flags held even"}, int'({e_perr, e_ferr}), int'({pe_e, fe}));
      end
      rx_in     = line_at(d, p, s, n);
      clr_count = clr_at_dv && (n == DV_N);
    end
    chk({tag, " busy window"}, int'(busy_bad), 0);
    chk({tag, " strobe count even"}, dv_e, 1);
    chk({tag, " strobe count odd"}, dv_o, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  vec_t tab[$];
  logic [W-1:0] saved_data;
  logic [W-1:0] rd;
  logic         rp, rs;
  int           dv_seen;

  initial begin
    tab.push_back('{4'hB, 1'b1, 1'b1, 1'b0, 1'b0});
    tab.push_back('{4'hB, 1'b0, 1'b1, 1'b1, 1'b0});
    tab.push_back('{4'h5, 1'b0, 1'b0, 1'b0, 1'b1});
    tab.push_back('{4'h3, 1'b0, 1'b1, 1'b0, 1'b0});
    tab.push_back('{4'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    tab.push_back('{4'hF, 1'b1, 1'b1, 1'b1, 1'b0});
    tab.push_back('{4'h8, 1'b1, 1'b1, 1'b0, 1'b0});
    tab.push_back('{4'h7, 1'b0, 1'b0, 1'b1, 1'b1});

    repeat (3) @(negedge clk);
    chk("reset data_out", int'(e_data), 0);
    chk("reset data_valid", int'(e_valid), 0);
    chk("reset flags", int'({e_perr, e_ferr}), 0);
    chk("reset busy", int'(e_busy), 0);
    chk("reset err_count", int'(e_cnt), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    foreach (tab[i])
      send_frame(tab[i].data, tab[i].par, tab[i].stop, 1'b0, 1'b1,
                 tab[i].exp_pe, tab[i].exp_fe, $sformatf("tab%0d", i));

    // One-cycle low glitch: START rejects it at the half-bit check.
    saved_data = e_data;
    dv_seen = 0;
    @(negedge clk);
    rx_in = 1'b0;
    @(negedge clk);
    chk("glitch busy c1", int'(e_busy), 1);
    rx_in = 1'b1;
    @(negedge clk);
    chk("glitch busy c2", int'(e_busy), 1);
    @(negedge clk);
    chk("glitch busy c3", int'(e_busy), 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (e_valid || o_valid) dv_seen++;
    end
    chk("glitch no strobe", dv_seen, 0);
    chk("glitch data_out held", int'(e_data), int'(saved_data));
    chk("glitch err_count held", int'(e_cnt), exp_cnt_e);

    for (int i = 0; i < 40; i++) begin
      rd = W'($urandom_range(0, (1 << W) - 1));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rd, rp, rs, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of the data bits abandons the frame.
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      rx_in = line_at(4'hA, 1'b0, 1'b1, n);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset data_out", int'(e_data), 0);
    chk("midreset valid", int'(e_valid), 0);
    chk("midreset flags", int'({e_perr, e_ferr, o_perr, o_ferr}), 0);
    chk("midreset busy", int'({e_busy, o_busy}), 0);
    chk("midreset err_count", int'(e_cnt), 0);
    rst_n = 1'b1;
    rx_in = 1'b1;
    exp_cnt_e = 0;
    exp_cnt_o = 0;
    dv_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (e_valid || o_valid || e_busy) dv_seen++;
    end
    chk("midreset quiet", dv_seen, 0);
    send_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "after_reset");

    // Saturate the even instance's counter with parity errors.
    for (int i = 0; i < 256; i++) begin
      rd = W'($urandom_range(0, (1 << W) - 1));
      rp = ~ref_perr(rd, 1'b0, 1'b0);
      send_frame(rd, rp, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("sat%0d", i));
    end
    chk("saturated err_count", int'(e_cnt), 255);
    send_frame(4'hB, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "clr_vs_inc");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Serial receiver that checks parity on incoming frames; the checking end of our reduction-XOR parity generation.
- Frame format: start bit, DATA_W data bits (LSB first), one parity bit, one stop bit.
- Per frame it outputs the data word, a one-cycle valid strobe, parity and framing error flags, and a saturating error counter.
- Sits after an upstream synchroniser; rx_in is already synchronous to clk.

Parameters:
- DATA_W, 4, data bits per frame (1..16).
- CLKS_PER_BIT, 4, clk cycles per serial bit; even, >= 2.
- PARITY_ODD, 0, 0 = even parity (parity bit = ^data), 1 = odd parity (parity bit = ~^data).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- rx_in  input  1  serial line; idle high.
- clr_count  input  1  synchronous clear of err_count.
- data_out  output  DATA_W  last received data word.
- data_valid  output  1  one-cycle pulse per completed frame.
- parity_err  output  1  parity mismatch for the frame flagged by data_valid.
- frame_err  output  1  stop bit sampled 0 for the frame flagged by data_valid.
- busy  output  1  high in any state other than IDLE.
- err_count  output  8  frames with parity_err or frame_err; saturates at 255.

Behaviour:
- Reset: rst_n low at a rising edge forces state IDLE and clears bit counter, bit index and shift register. It also sets data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0 and err_count=0. Reset mid-frame abandons the frame with no strobe.
- Let H = CLKS_PER_BIT/2 and C = CLKS_PER_BIT. cnt is the cycle counter.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if rx_in==0, go to START with cnt=0.
- START: cnt increments each cycle. At cnt==H-1, sample rx_in:
  - rx_in==0: go to DATA with cnt=0, idx=0.
  - rx_in==1: treat as a glitch and return to IDLE. No flags, no strobe, err_count unchanged.
- DATA: at cnt==C-1, write rx_in into shift bit idx (LSB first) and set cnt=0. After bit DATA_W-1, go to PARITY.
- PARITY: at cnt==C-1, capture rx_in as p, set cnt=0 and go to STOP.
- STOP: at cnt==C-1, sample the stop bit. On the next edge:
  - data_out <= shift register.
  - data_valid <= 1 for exactly one cycle.
  - parity_err <= (p != (^data ^ PARITY_ODD)).
  - frame_err <= ~stop.
  - state returns to IDLE.
- Timing: sampling points fall at bit centres. If T is the first cycle IDLE sees rx_in==0, the stop bit is sampled at T+H+C*(DATA_W+2) and data_valid is high at T+H+C*(DATA_W+2)+1. With the defaults this is T+27.
- Error flag hold: parity_err and frame_err hold their values until the next data_valid. data_out updates even on error frames.
- busy is registered and mirrors (state != IDLE).
- Back-to-back frames: in the cycle data_valid is high the FSM is in IDLE and may detect a new start immediately.
- err_count: increments by 1 in the data_valid cycle when parity_err|frame_err, and holds at 255.
  - clr_count clears it on the next edge.
  - clr_count wins over a simultaneous increment.
- rx_in changes between sample points are ignored. Only the centre samples matter.

Test Plan:
- Defaults, send data 4'hB (bits 1,1,0,1), parity 1, stop 1 -> data_valid pulse at T+27, data_out=4'hB, parity_err=0, frame_err=0, err_count=0, busy high T+1..T+26.
- Same frame with parity bit 0 -> data_out=4'hB, parity_err=1, frame_err=0, err_count=1. Repeat with PARITY_ODD=1 and parity 0 -> parity_err=0.
- Frame 4'h5 with correct parity and stop bit 0 -> frame_err=1, parity_err=0, err_count increments.
- rx_in low for 1 cycle then high -> no data_valid, busy high for 2 cycles then low, outputs unchanged.
- rst_n low for 1 cycle during DATA of a frame -> all outputs 0, no strobe. A new valid frame afterwards (data 4'h3, parity 0) is received correctly.
- Send 256 parity-error frames -> err_count stops at 255. Assert clr_count in the same cycle as the next error's data_valid -> err_count=0.
